// File: rtl/mbtrain_repair_tx_param.sv
// MBTRAIN REPAIR TX: INIT -> DEGRADE -> END handshake with per-request timeout/retry; all outputs registered.
// A request is issued on the edge after entry; o_valid_tx is held until the sideband TX reports completion with the partner RX idle.
module mbtrain_repair_tx_param #(
  parameter int N_GROUPS    = 2,
  parameter int TIMEOUT_CYC = 1024,
  parameter int MAX_RETRY   = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_en,
  input  logic [3:0]          i_sideband_message,
  input  logic                i_sideband_valid,
  input  logic                i_busy_negedge_detected,
  input  logic                i_valid_rx,
  input  logic [N_GROUPS-1:0] i_group_functional,
  output logic [3:0]          o_sideband_message,
  output logic                o_valid_tx,
  output logic [N_GROUPS-1:0] o_lane_mask,
  output logic                o_test_ack,
  output logic                o_error
);

  localparam logic [3:0] INIT_REQ     = 4'b0001;
  localparam logic [3:0] INIT_RESP    = 4'b0010;
  localparam logic [3:0] END_REQ      = 4'b0101;
  localparam logic [3:0] END_RESP     = 4'b0110;
  localparam logic [3:0] DEGRADE_REQ  = 4'b0111;
  localparam logic [3:0] DEGRADE_RESP = 4'b1000;

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYC - 1);
  localparam logic [3:0]  RETRY_MAX  = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE, S_INIT, S_DEGRADE, S_END, S_DONE, S_FAIL
  } state_t;

  state_t              state, state_nxt;
  logic [15:0]         timer, timer_nxt;
  logic [3:0]          retry, retry_nxt;
  logic [3:0]          msg_nxt;
  logic                valid_tx_nxt;
  logic [N_GROUPS-1:0] mask_nxt;
  logic                ack_nxt;
  logic                error_nxt;
  logic [3:0]          exp_resp;
  logic                resp_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      timer              <= '0;
      retry              <= '0;
      o_sideband_message <= '0;
      o_valid_tx         <= 1'b0;
      o_lane_mask        <= '0;
      o_test_ack         <= 1'b0;
      o_error            <= 1'b0;
    end else begin
      state              <= state_nxt;
      timer              <= timer_nxt;
      retry              <= retry_nxt;
      o_sideband_message <= msg_nxt;
      o_valid_tx         <= valid_tx_nxt;
      o_lane_mask        <= mask_nxt;
      o_test_ack         <= ack_nxt;
      o_error            <= error_nxt;
    end
  end

  always_comb begin
    exp_resp = 4'b0000;
    case (state)
      S_INIT:    exp_resp = INIT_RESP;
      S_DEGRADE: exp_resp = DEGRADE_RESP;
      S_END:     exp_resp = END_RESP;
      default:   exp_resp = 4'b0000;
    endcase
  end

  assign resp_ok = i_sideband_valid && (i_sideband_message == exp_resp) &&
                   (state == S_INIT || state == S_DEGRADE || state == S_END);

  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer;
    retry_nxt    = retry;
    msg_nxt      = o_sideband_message;
    valid_tx_nxt = o_valid_tx;
    mask_nxt     = o_lane_mask;
    ack_nxt      = o_test_ack;
    error_nxt    = o_error;

    // Clear first so that any send below overrides it in the same cycle.
    if (i_busy_negedge_detected && !i_valid_rx) valid_tx_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (i_en) begin
          state_nxt    = S_INIT;
          msg_nxt      = INIT_REQ;
          valid_tx_nxt = 1'b1;
          timer_nxt    = '0;
          retry_nxt    = '0;
        end
      end
      S_INIT, S_DEGRADE, S_END: begin
        if (resp_ok) begin
          timer_nxt = '0;
          retry_nxt = '0;
          if (state == S_INIT) begin
            if (i_group_functional != '0) begin
              state_nxt    = S_DEGRADE;
              mask_nxt     = i_group_functional;
              msg_nxt      = DEGRADE_REQ;
              valid_tx_nxt = 1'b1;
            end else begin
              state_nxt    = S_FAIL;
              msg_nxt      = '0;
              valid_tx_nxt = 1'b0;
              ack_nxt      = 1'b1;
              error_nxt    = 1'b1;
            end
          end else if (state == S_DEGRADE) begin
            state_nxt    = S_END;
            msg_nxt      = END_REQ;
            valid_tx_nxt = 1'b1;
          end else begin
            state_nxt    = S_DONE;
            msg_nxt      = '0;
            valid_tx_nxt = 1'b0;
            ack_nxt      = 1'b1;
            error_nxt    = 1'b0;
          end
        end else if (timer == TIMER_LAST) begin
          if (retry < RETRY_MAX) begin
            // Re-send the same request code, which is still on o_sideband_message.
            valid_tx_nxt = 1'b1;
            timer_nxt    = '0;
            retry_nxt    = retry + 4'd1;
          end else begin
            state_nxt    = S_FAIL;
            msg_nxt      = '0;
            valid_tx_nxt = 1'b0;
            ack_nxt      = 1'b1;
            error_nxt    = 1'b1;
            timer_nxt    = '0;
            retry_nxt    = '0;
          end
        end else begin
          timer_nxt = timer + 16'd1;
        end
      end
      default: ;  // S_DONE / S_FAIL hold until i_en drops
    endcase

    if (!i_en) begin
      state_nxt    = IDLE;
      timer_nxt    = '0;
      retry_nxt    = '0;
      msg_nxt      = '0;
      valid_tx_nxt = 1'b0;
      mask_nxt     = '0;
      ack_nxt      = 1'b0;
      error_nxt    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mbtrain_repair_tx_param.sv
// Directed bench for mbtrain_repair_tx_param (N_GROUPS=2, TIMEOUT_CYC=8, MAX_RETRY=2).
module tb_mbtrain_repair_tx_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] sb_msg;
  logic       sb_vld;
  logic       busy_ne;
  logic       valid_rx;
  logic [1:0] grp;
  logic [3:0] out_msg;
  logic       out_vtx;
  logic [1:0] out_mask;
  logic       out_ack;
  logic       out_err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mbtrain_repair_tx_param #(
    .N_GROUPS(2), .TIMEOUT_CYC(8), .MAX_RETRY(2)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .i_en                   (en),
    .i_sideband_message     (sb_msg),
    .i_sideband_valid       (sb_vld),
    .i_busy_negedge_detected(busy_ne),
    .i_valid_rx             (valid_rx),
    .i_group_functional     (grp),
    .o_sideband_message     (out_msg),
    .o_valid_tx             (out_vtx),
    .o_lane_mask            (out_mask),
    .o_test_ack             (out_ack),
    .o_error                (out_err)
  );

  typedef struct {
    logic       en;
    logic [3:0] msg;
    logic       sbv;
    logic       busy;
    logic       vrx;
    logic [1:0] grp;
    logic [8:0] exp;
  } vec_t;

  // Expected output word: {msg, valid_tx, mask, ack, error}
  function automatic logic [8:0] pk(logic [3:0] m, logic v, logic [1:0] k, logic a, logic e);
    return {m, v, k, a, e};
  endfunction

  function automatic vec_t mk(logic e, logic [3:0] m, logic s, logic b, logic r,
                              logic [1:0] g, logic [8:0] x);
    vec_t t;
    t.en = e; t.msg = m; t.sbv = s; t.busy = b; t.vrx = r; t.grp = g; t.exp = x;
    return t;
  endfunction

  task automatic check(string name, logic [8:0] exp);
    logic [8:0] got;
    got = {out_msg, out_vtx, out_mask, out_ack, out_err};
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got msg=%b vtx=%b mask=%b ack=%b err=%b, expected msg=%b vtx=%b mask=%b ack=%b err=%b",
                  name, got[8:5], got[4], got[3:2], got[1], got[0],
                  exp[8:5], exp[4], exp[3:2], exp[1], exp[0]);
  endtask

  task automatic drive(logic e, logic [3:0] m, logic s, logic b, logic r, logic [1:0] g);
    en = e; sb_msg = m; sb_vld = s; busy_ne = b; valid_rx = r; grp = g;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[18];

  initial begin
    vecs[0]  = mk(0, 4'h0, 0, 0, 0, 2'b00, pk(4'h0, 0, 2'b00, 0, 0));
    vecs[1]  = mk(1, 4'h0, 0, 0, 0, 2'b00, pk(4'h1, 1, 2'b00, 0, 0));
    vecs[2]  = mk(1, 4'h0, 0, 1, 1, 2'b00, pk(4'h1, 1, 2'b00, 0, 0));
    vecs[3]  = mk(1, 4'h0, 0, 1, 0, 2'b00, pk(4'h1, 0, 2'b00, 0, 0));
    vecs[4]  = mk(1, 4'h6, 1, 0, 0, 2'b01, pk(4'h1, 0, 2'b00, 0, 0));
    vecs[5]  = mk(1, 4'h2, 1, 0, 0, 2'b01, pk(4'h7, 1, 2'b01, 0, 0));
    vecs[6]  = mk(1, 4'h0, 0, 1, 0, 2'b01, pk(4'h7, 0, 2'b01, 0, 0));
    vecs[7]  = mk(1, 4'h8, 1, 1, 0, 2'b01, pk(4'h5, 1, 2'b01, 0, 0));
    vecs[8]  = mk(1, 4'h6, 1, 1, 0, 2'b10, pk(4'h0, 0, 2'b01, 1, 0));
    vecs[9]  = mk(1, 4'h0, 0, 0, 0, 2'b00, pk(4'h0, 0, 2'b01, 1, 0));
    vecs[10] = mk(0, 4'h0, 0, 0, 0, 2'b00, pk(4'h0, 0, 2'b00, 0, 0));
    vecs[11] = mk(1, 4'h0, 0, 0, 0, 2'b00, pk(4'h1, 1, 2'b00, 0, 0));
    vecs[12] = mk(1, 4'h2, 1, 0, 0, 2'b11, pk(4'h7, 1, 2'b11, 0, 0));
    vecs[13] = mk(0, 4'h8, 1, 0, 0, 2'b11, pk(4'h0, 0, 2'b00, 0, 0));
    vecs[14] = mk(1, 4'h0, 0, 0, 0, 2'b00, pk(4'h1, 1, 2'b00, 0, 0));
    vecs[15] = mk(1, 4'h2, 1, 0, 0, 2'b00, pk(4'h0, 0, 2'b00, 1, 1));
    vecs[16] = mk(1, 4'h0, 0, 0, 0, 2'b00, pk(4'h0, 0, 2'b00, 1, 1));
    vecs[17] = mk(0, 4'h0, 0, 0, 0, 2'b00, pk(4'h0, 0, 2'b00, 0, 0));

    rst_n = 1'b0;
    drive(0, 4'h0, 0, 0, 0, 2'b00);
    #12;
    check("reset", pk(4'h0, 0, 2'b00, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;

    // Table: normal pass, ignored wrong code, busy hold, en-drop with response, zero-mask fail
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].en, vecs[i].msg, vecs[i].sbv, vecs[i].busy, vecs[i].vrx, vecs[i].grp);
      tick();
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Timeout with retries and final fail; busy_ne keeps valid_tx to single-cycle pulses
    for (int c = 1; c <= 26; c++) begin
      drive(1, 4'h0, 0, 1, 0, 2'b00);
      tick();
      if (c >= 25) check($sformatf("retry_c%0d", c), pk(4'h0, 0, 2'b00, 1, 1));
      else check($sformatf("retry_c%0d", c),
                 pk(4'h1, (c == 1 || c == 9 || c == 17), 2'b00, 0, 0));
    end
    drive(0, 4'h0, 0, 0, 0, 2'b00);
    tick();
    check("retry_exit", pk(4'h0, 0, 2'b00, 0, 0));

    // INIT_RESP in the timeout cycle; then DEGRADE timer must restart from 0
    for (int c = 1; c <= 17; c++) begin
      if (c == 9) drive(1, 4'h2, 1, 1, 0, 2'b10);
      else drive(1, 4'h0, 0, 1, 0, 2'b10);
      tick();
      if (c < 9) check($sformatf("tmo_resp_c%0d", c), pk(4'h1, (c == 1), 2'b00, 0, 0));
      else check($sformatf("tmo_resp_c%0d", c), pk(4'h7, (c == 9 || c == 17), 2'b10, 0, 0));
    end
    drive(1, 4'h8, 1, 0, 0, 2'b10);
    tick();
    check("tmo_end_req", pk(4'h5, 1, 2'b10, 0, 0));
    drive(1, 4'h6, 1, 1, 0, 2'b01);
    tick();
    check("tmo_done", pk(4'h0, 0, 2'b10, 1, 0));
    drive(0, 4'h0, 0, 0, 0, 2'b00);
    tick();
    check("tmo_exit", pk(4'h0, 0, 2'b00, 0, 0));

    // Asynchronous reset mid-request, checked before any clock edge
    drive(1, 4'h0, 0, 0, 0, 2'b00);
    tick();
    check("pre_async", pk(4'h1, 1, 2'b00, 0, 0));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", pk(4'h0, 0, 2'b00, 0, 0));
    drive(0, 4'h0, 0, 0, 0, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_reset_idle", pk(4'h0, 0, 2'b00, 0, 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
